// File: rtl/alu_sequencer.sv
// Instruction sequencer for the ALU en_in/en_out interface: decodes 16-bit words, reads operands
// from an 8-entry register file, issues one op, waits for completion and writes the result back.
module alu_sequencer #(
  parameter int unsigned DWIDTH  = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid_i,
  output logic              instr_ready_o,
  input  logic [15:0]       instr_i,
  output logic [2:0]        alu_func_o,
  output logic [DWIDTH-1:0] alu_a_o,
  output logic [DWIDTH-1:0] alu_b_o,
  output logic              alu_en_o,
  input  logic              alu_done_i,
  input  logic [DWIDTH-1:0] alu_res_i,
  output logic              done_o,
  output logic              err_o,
  input  logic              host_we_i,
  input  logic [2:0]        host_waddr_i,
  input  logic [DWIDTH-1:0] host_wdata_i,
  input  logic [2:0]        host_raddr_i,
  output logic [DWIDTH-1:0] host_rdata_o
);

  localparam int unsigned TimerW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e              state_q;
  logic [DWIDTH-1:0]   regs_q [8];
  logic [2:0]          rd_q;
  logic [TimerW-1:0]   timer_q;
  logic [2:0]          func_q;
  logic [DWIDTH-1:0]   a_q, b_q;
  logic                en_q, done_q, err_q;

  logic [2:0]          dec_func, dec_rd, dec_ra, dec_rb;
  logic                dec_legal;
  logic [DWIDTH-1:0]   op_a, op_b;
  logic                unused_reserved;

  assign dec_func  = instr_i[15:13];
  assign dec_rd    = instr_i[12:10];
  assign dec_ra    = instr_i[9:7];
  assign dec_rb    = instr_i[6:4];
  assign dec_legal = (dec_func <= 3'd4);
  assign unused_reserved = ^instr_i[3:0];

  // A host write landing on the accept edge must be visible to the issued operands.
  always_comb begin
    op_a = regs_q[dec_ra];
    op_b = regs_q[dec_rb];
    if (host_we_i && (host_waddr_i == dec_ra)) op_a = host_wdata_i;
    if (host_we_i && (host_waddr_i == dec_rb)) op_b = host_wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
      rd_q    <= '0;
      timer_q <= '0;
      func_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (host_we_i) regs_q[host_waddr_i] <= host_wdata_i;
          if (instr_valid_i) begin
            if (dec_legal) begin
              func_q  <= dec_func;
              a_q     <= op_a;
              b_q     <= op_b;
              rd_q    <= dec_rd;
              en_q    <= 1'b1;
              state_q <= StIssue;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        StIssue: begin
          en_q    <= 1'b0;
          timer_q <= '0;
          state_q <= StWait;
        end
        StWait: begin
          if (alu_done_i) begin
            regs_q[rd_q] <= alu_res_i;
            done_q       <= 1'b1;
            state_q      <= StIdle;
          end else if (timer_q == TimerW'(TIMEOUT - 1)) begin
            // TIMEOUT cycles spent in WAIT without a strobe
            err_q   <= 1'b1;
            state_q <= StIdle;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign instr_ready_o = (state_q == StIdle);
  assign alu_func_o    = func_q;
  assign alu_a_o       = a_q;
  assign alu_b_o       = b_q;
  assign alu_en_o      = en_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign host_rdata_o  = regs_q[host_raddr_i];

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: directed instructions with hand-computed operands/results,
// a simple 1-cycle ALU model, and a monitor that checks every issue and every done/err pulse.
module tb_alu_sequencer;

  localparam int DW = 16;
  localparam int TO = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          instr_valid = 1'b0;
  logic          instr_ready_o;
  logic [15:0]   instr = '0;
  logic [2:0]    alu_func_o;
  logic [DW-1:0] alu_a_o, alu_b_o;
  logic          alu_en_o;
  logic          alu_done;
  logic [DW-1:0] alu_res;
  logic          done_o, err_o;
  logic          host_we = 1'b0;
  logic [2:0]    host_waddr = '0;
  logic [DW-1:0] host_wdata = '0;
  logic [2:0]    host_raddr = '0;
  logic [DW-1:0] host_rdata_o;

  int checks = 0;
  int failures = 0;
  bit hold = 1'b0;
  int cnt;

  typedef struct {
    logic [2:0]    f;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } iss_t;

  iss_t iq[$];
  bit   rq[$];

  always #5 clk = ~clk;

  alu_sequencer #(.DWIDTH(DW), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_valid_i (instr_valid),
    .instr_ready_o (instr_ready_o),
    .instr_i       (instr),
    .alu_func_o    (alu_func_o),
    .alu_a_o       (alu_a_o),
    .alu_b_o       (alu_b_o),
    .alu_en_o      (alu_en_o),
    .alu_done_i    (alu_done),
    .alu_res_i     (alu_res),
    .done_o        (done_o),
    .err_o         (err_o),
    .host_we_i     (host_we),
    .host_waddr_i  (host_waddr),
    .host_wdata_i  (host_wdata),
    .host_raddr_i  (host_raddr),
    .host_rdata_o  (host_rdata_o)
  );

  // One-cycle ALU; 'hold' suppresses the completion strobe.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_done <= 1'b0;
      alu_res  <= '0;
    end else begin
      alu_done <= alu_en_o && !hold;
      case (alu_func_o)
        3'd0:    alu_res <= alu_b_o;
        3'd1:    alu_res <= alu_a_o + alu_b_o;
        3'd2:    alu_res <= alu_a_o - alu_b_o;
        3'd3:    alu_res <= alu_a_o & alu_b_o;
        3'd4:    alu_res <= alu_a_o | alu_b_o;
        default: alu_res <= '0;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got 1 expected 0", name);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (alu_en_o) begin
        if (iq.size() == 0) fail("unexpected_alu_en");
        else begin
          iss_t e;
          e = iq.pop_front();
          check("alu_func", 32'(alu_func_o), 32'(e.f));
          check("alu_a", 32'(alu_a_o), 32'(e.a));
          check("alu_b", 32'(alu_b_o), 32'(e.b));
        end
      end
      if (done_o && err_o) fail("done_err_overlap");
      else if (done_o || err_o) begin
        if (rq.size() == 0) fail("unexpected_resp");
        else check("resp_is_err", 32'(err_o), 32'(rq.pop_front()));
      end
    end
  end

  task automatic host_wr(input logic [2:0] ad, input logic [DW-1:0] d);
    @(negedge clk);
    host_we = 1'b1; host_waddr = ad; host_wdata = d;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  // Call off-edge; returns 1 time unit after the accepting edge.
  task automatic issue(input logic [2:0] f, input logic [2:0] rd, input logic [2:0] ra,
                       input logic [2:0] rb, input logic [DW-1:0] ea, input logic [DW-1:0] eb,
                       input bit exp_err, input bit keep);
    int n = 0;
    instr_valid = 1'b1;
    instr = {f, rd, ra, rb, 4'h0};
    while (!instr_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready_o) fail("accept_timeout");
    else begin
      if (f <= 3'd4) iq.push_back('{f, ea, eb});
      rq.push_back(exp_err);
      @(posedge clk);
    end
    #1;
    if (!keep) instr_valid = 1'b0;
  endtask

  task automatic wait_resp(output int c);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!(done_o || err_o) && c < 100);
    if (!(done_o || err_o)) fail("resp_timeout");
  endtask

  task automatic chk_reg(input string name, input logic [2:0] ad, input logic [DW-1:0] exp);
    host_raddr = ad;
    #1;
    check(name, 32'(host_rdata_o), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ready", 32'(instr_ready_o), 32'd1);
    check("rst_alu_en", 32'(alu_en_o), 32'd0);
    check("rst_done_err", 32'({done_o, err_o}), 32'd0);
    check("rst_alu_ab", 32'({alu_a_o, alu_b_o}), 32'd0);
    chk_reg("rst_r3", 3'd3, 16'h0);

    // ADD R3 = R1 + R2
    host_wr(3'd1, 16'd5);
    host_wr(3'd2, 16'd3);
    @(negedge clk);
    issue(3'd1, 3'd3, 3'd1, 3'd2, 16'd5, 16'd3, 1'b0, 1'b0);
    wait_resp(cnt);
    check("add_latency", 32'(cnt), 32'd3);
    chk_reg("add_r3", 3'd3, 16'd8);

    // SUB wraps
    host_wr(3'd1, 16'h0000);
    host_wr(3'd2, 16'h0001);
    @(negedge clk);
    issue(3'd2, 3'd4, 3'd1, 3'd2, 16'h0000, 16'h0001, 1'b0, 1'b0);
    wait_resp(cnt);
    chk_reg("sub_r4", 3'd4, 16'hFFFF);

    // AND / OR / MOV
    host_wr(3'd5, 16'hF0F0);
    host_wr(3'd6, 16'h0FF0);
    @(negedge clk);
    issue(3'd3, 3'd7, 3'd5, 3'd6, 16'hF0F0, 16'h0FF0, 1'b0, 1'b0);
    wait_resp(cnt);
    chk_reg("and_r7", 3'd7, 16'h00F0);
    @(negedge clk);
    issue(3'd4, 3'd7, 3'd5, 3'd6, 16'hF0F0, 16'h0FF0, 1'b0, 1'b0);
    wait_resp(cnt);
    chk_reg("or_r7", 3'd7, 16'hFFF0);
    @(negedge clk);
    issue(3'd0, 3'd0, 3'd5, 3'd6, 16'hF0F0, 16'h0FF0, 1'b0, 1'b0);
    wait_resp(cnt);
    chk_reg("mov_r0", 3'd0, 16'h0FF0);

    // Illegal func
    @(negedge clk);
    issue(3'd7, 3'd1, 3'd5, 3'd6, 16'h0, 16'h0, 1'b1, 1'b0);
    wait_resp(cnt);
    check("illegal_latency", 32'(cnt), 32'd1);
    check("illegal_ready", 32'(instr_ready_o), 32'd1);
    repeat (3) @(negedge clk);
    chk_reg("illegal_r1", 3'd1, 16'h0000);
    chk_reg("illegal_r7", 3'd7, 16'hFFF0);

    // Timeout: rd must keep its value
    hold = 1'b1;
    host_wr(3'd1, 16'd5);
    host_wr(3'd2, 16'd3);
    @(negedge clk);
    issue(3'd1, 3'd6, 3'd1, 3'd2, 16'd5, 16'd3, 1'b1, 1'b0);
    wait_resp(cnt);
    check("timeout_latency", 32'(cnt), 32'(TO + 2));
    chk_reg("timeout_r6", 3'd6, 16'h0FF0);
    hold = 1'b0;
    @(negedge clk);
    issue(3'd1, 3'd6, 3'd1, 3'd2, 16'd5, 16'd3, 1'b0, 1'b0);
    wait_resp(cnt);
    check("post_timeout_latency", 32'(cnt), 32'd3);
    chk_reg("post_timeout_r6", 3'd6, 16'd8);

    // Back-to-back with dependency on R3
    host_wr(3'd3, 16'd0);
    @(negedge clk);
    issue(3'd1, 3'd3, 3'd1, 3'd2, 16'd5, 16'd3, 1'b0, 1'b1);
    @(negedge clk);
    check("b2b_ready_low", 32'(instr_ready_o), 32'd0);
    issue(3'd1, 3'd4, 3'd3, 3'd1, 16'd8, 16'd5, 1'b0, 1'b0);
    wait_resp(cnt);
    chk_reg("b2b_r3", 3'd3, 16'd8);
    chk_reg("b2b_r4", 3'd4, 16'd13);

    // Host write during ISSUE is dropped
    @(negedge clk);
    issue(3'd1, 3'd5, 3'd1, 3'd2, 16'd5, 16'd3, 1'b0, 1'b0);
    host_we = 1'b1; host_waddr = 3'd1; host_wdata = 16'h0077;
    @(posedge clk);
    #1;
    host_we = 1'b0;
    wait_resp(cnt);
    chk_reg("busy_hostwr_r1", 3'd1, 16'd5);
    chk_reg("busy_hostwr_r5", 3'd5, 16'd8);

    // Host write on the accept edge is forwarded
    @(negedge clk);
    host_we = 1'b1; host_waddr = 3'd1; host_wdata = 16'd9;
    issue(3'd1, 3'd2, 3'd1, 3'd1, 16'd9, 16'd9, 1'b0, 1'b0);
    host_we = 1'b0;
    wait_resp(cnt);
    chk_reg("fwd_r2", 3'd2, 16'd18);
    chk_reg("fwd_r1", 3'd1, 16'd9);

    // Reset asserted in WAIT
    hold = 1'b1;
    @(negedge clk);
    issue(3'd1, 3'd5, 3'd1, 3'd3, 16'd9, 16'd8, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_alu_en", 32'(alu_en_o), 32'd0);
    check("abort_alu_func", 32'(alu_func_o), 32'd0);
    check("abort_alu_a", 32'(alu_a_o), 32'd0);
    check("abort_done_err", 32'({done_o, err_o}), 32'd0);
    chk_reg("abort_r5", 3'd5, 16'h0);
    iq.delete();
    rq.delete();
    hold = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort_ready", 32'(instr_ready_o), 32'd1);
    chk_reg("abort_r1", 3'd1, 16'h0);
    repeat (3) @(negedge clk);

    check("sb_empty", 32'(iq.size() + rq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
